clk_int_div: RTL and testbench



---
 rtl/clk_int_div.sv | 147 ++++++++++++++
 tb/tb_clk_int_div.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_int_div.sv
// Programmable integer clock divider: divided clock plus one-cycle enable strobe.
// Ratio updates use valid/ready and are applied only on a period boundary.
//
// Ports:
//   clk_i        source clock, all logic on its rising edge
//   rst_i        synchronous active-high reset
//   div_valid_i  new ratio offered
//   div_i        offered ratio (values below 2 are clamped to 2)
//   div_ready_o  update slot free
//   cur_div_o    ratio currently in effect
//   clk_o        divided clock, high for floor(N/2) of every N cycles
//   div_en_o     strobe in the first high cycle of each divided period
//   gate_i       request clean stop at the next period boundary (macro only)
//   gated_o      divider stopped (macro only)
//
// Optional feature: define CLK_INT_DIV_GATE_EN to add gate_i/gated_o.

module clk_int_div #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned RST_DIV   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 div_valid_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 div_ready_o,
    output logic [DIV_WIDTH-1:0] cur_div_o,
    output logic                 clk_o,
    output logic                 div_en_o
`ifdef CLK_INT_DIV_GATE_EN
    ,
    input  logic                 gate_i,
    output logic                 gated_o
`endif
);

    localparam logic [DIV_WIDTH-1:0] RstDiv = DIV_WIDTH'(RST_DIV);
    localparam logic [DIV_WIDTH-1:0] MinDiv = DIV_WIDTH'(2);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] cnt_step;
    logic [DIV_WIDTH-1:0] n_q;
    logic [DIV_WIDTH-1:0] n_d;
    logic [DIV_WIDTH-1:0] pend_val_q;
    logic [DIV_WIDTH-1:0] pend_val_d;
    logic                 pend_q;
    logic                 pend_d;
    logic                 clk_q;
    logic                 clk_d;
    logic                 en_q;
    logic                 en_d;
    logic                 wrap;
    logic                 xfer;
    logic                 apply;

`ifdef CLK_INT_DIV_GATE_EN
    typedef enum logic {
        RUN,
        GATED
    } gate_state_e;

    gate_state_e state_q;
    gate_state_e state_d;
`endif

    always_comb begin
        cnt_step = (cnt_q == n_q - DIV_WIDTH'(1)) ? '0
                                                   : cnt_q + DIV_WIDTH'(1);
        wrap     = (cnt_step == '0);
        xfer     = div_valid_i & ~pend_q;
        // A value accepted on this edge has pend_q low, so it can
        // never be applied on the same edge it was accepted.
        apply    = pend_q & wrap;
`ifdef CLK_INT_DIV_GATE_EN
        // While stopped there is no period to protect.
        if (state_q == GATED) begin
            apply = pend_q;
        end
`endif
        cnt_d      = cnt_step;
        n_d        = apply ? pend_val_q : n_q;
        pend_d     = xfer | (pend_q & ~apply);
        pend_val_d = pend_val_q;
        if (xfer) begin
            pend_val_d = (div_i < MinDiv) ? MinDiv : div_i;
        end
        // Compare against the ratio of the period being entered.
        clk_d = (cnt_step < (n_d >> 1));
        en_d  = wrap;
`ifdef CLK_INT_DIV_GATE_EN
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (wrap && gate_i) begin
                    state_d = GATED;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    en_d    = 1'b0;
                end
            end
            GATED: begin
                // Leaving GATED lands in the exact post-reset state.
                cnt_d = '0;
                clk_d = 1'b0;
                en_d  = 1'b0;
                if (!gate_i) begin
                    state_d = RUN;
                end
            end
        endcase
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            n_q        <= RstDiv;
            pend_q     <= 1'b0;
            pend_val_q <= RstDiv;
            clk_q      <= 1'b0;
            en_q       <= 1'b0;
`ifdef CLK_INT_DIV_GATE_EN
            state_q    <= RUN;
`endif
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            clk_q      <= clk_d;
            en_q       <= en_d;
`ifdef CLK_INT_DIV_GATE_EN
            state_q    <= state_d;
`endif
        end
    end

    assign div_ready_o = ~pend_q;
    assign cur_div_o   = n_q;
    assign clk_o       = clk_q;
    assign div_en_o    = en_q;
`ifdef CLK_INT_DIV_GATE_EN
    assign gated_o     = (state_q == GATED);
`endif

endmodule

// File: tb/tb_clk_int_div.sv
// Testbench for clk_int_div: random ratio offers, resets and gating
// checked cycle by cycle against a period-level reference model.

module tb_clk_int_div;

    localparam int W       = 8;
    localparam int RST_DIV = 2;

    logic         clk_i       = 1'b0;
    logic         rst_i       = 1'b1;
    logic         div_valid_i = 1'b0;
    logic [W-1:0] div_i       = '0;
    logic         div_ready_o;
    logic [W-1:0] cur_div_o;
    logic         clk_o;
    logic         div_en_o;
`ifdef CLK_INT_DIV_GATE_EN
    logic         gate_i      = 1'b0;
    logic         gated_o;
`endif

    clk_int_div #(
        .DIV_WIDTH (W),
        .RST_DIV   (RST_DIV)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_valid_i (div_valid_i),
        .div_i       (div_i),
        .div_ready_o (div_ready_o),
        .cur_div_o   (cur_div_o),
        .clk_o       (clk_o),
        .div_en_o    (div_en_o)
`ifdef CLK_INT_DIV_GATE_EN
        ,
        .gate_i      (gate_i),
        .gated_o     (gated_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Accepted ratio (already clamped) and the edge that accepted it.
    typedef struct {
        int n;
        int stamp;
    } acc_t;

    acc_t acc_q[$];

    int edge_cnt  = 0;
    bit rst_seen  = 1'b0;
    bit gate_seen = 1'b0;

    always @(posedge clk_i) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= rst_i;
`ifdef CLK_INT_DIV_GATE_EN
        gate_seen <= gate_i;
`endif
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int e,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d",
                     name, e, got, exp);
        end
    endtask

    // Reference model state: ratio in force, start edge of the
    // current period (-1 when idle), edge of the next period start.
    bit armed     = 1'b0;
    int cur_n     = RST_DIV;
    int next_wrap = 0;
    int pstart    = -1;
    bit gated_m   = 1'b0;

    task automatic apply_pending(input int e);
        if (acc_q.size() > 0 && acc_q[0].stamp < e) begin
            cur_n = acc_q[0].n;
            void'(acc_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            int e;
            @(negedge clk_i);
            e = edge_cnt;
            if (rst_seen) begin
                acc_q.delete();
                cur_n     = RST_DIV;
                next_wrap = e + RST_DIV;
                pstart    = -1;
                gated_m   = 1'b0;
                armed     = 1'b1;
            end else if (armed) begin
                if (gated_m) begin
                    apply_pending(e);
                    if (!gate_seen) begin
                        gated_m   = 1'b0;
                        next_wrap = e + cur_n;
                    end
                end else if (e == next_wrap) begin
                    apply_pending(e);
                    if (gate_seen) begin
                        gated_m = 1'b1;
                        pstart  = -1;
                    end else begin
                        pstart    = e;
                        next_wrap = e + cur_n;
                    end
                end
            end
            if (armed) begin
                check("clk_o", e, clk_o,
                      32'(pstart >= 0 && (e - pstart) < cur_n / 2));
                check("div_en_o", e, div_en_o, 32'(pstart == e));
                check("cur_div_o", e, cur_div_o, 32'(cur_n));
                check("div_ready_o", e, div_ready_o,
                      32'(acc_q.size() == 0));
`ifdef CLK_INT_DIV_GATE_EN
                check("gated_o", e, gated_o, 32'(gated_m));
`endif
            end
        end
    end

    bit           offering  = 1'b0;
    logic [W-1:0] offer_val = '0;

    function automatic logic [W-1:0] pick();
        if ($urandom_range(9) == 0) begin
            return W'($urandom_range(40, 14));
        end
        return W'($urandom_range(13, 0));
    endfunction

    task automatic offer(input int v);
        offering  = 1'b1;
        offer_val = W'(v);
    endtask

    // Sets inputs for the next rising edge; runs after the monitor.
    task automatic cycle(input bit rst, input int p_offer,
                         input int p_gate);
        int v;
        @(negedge clk_i);
        #1;
        rst_i = rst;
        if (!offering && int'($urandom_range(99)) < p_offer) begin
            offering  = 1'b1;
            offer_val = pick();
        end
        div_valid_i = offering && !rst;
        div_i = div_valid_i ? offer_val : W'($urandom);
`ifdef CLK_INT_DIV_GATE_EN
        if (int'($urandom_range(99)) < p_gate) begin
            gate_i = ~gate_i;
        end
`else
        if (p_gate < 0) begin
            $display("bad gate probability");
        end
`endif
        if (div_valid_i && div_ready_o) begin
            v = int'(div_i);
            acc_q.push_back('{n: (v < 2) ? 2 : v, stamp: edge_cnt + 1});
            offering = 1'b0;
        end
    endtask

    initial begin
        int k;
        repeat (3) cycle(1'b1, 0, 0);
        repeat (12) cycle(1'b0, 0, 0);

        offer(5);
        repeat (25) cycle(1'b0, 0, 0);

        offer(4);
        repeat (14) cycle(1'b0, 0, 0);
        k = 0;
        do begin
            cycle(1'b0, 0, 0);
            k++;
        end while (div_en_o !== 1'b1 && k < 40);
        check("wait_period_start", edge_cnt, div_en_o, 32'd1);
        repeat (2) cycle(1'b0, 0, 0);
        offer(6);
        repeat (20) cycle(1'b0, 0, 0);

        offer(0);
        cycle(1'b0, 0, 0);
        offer(9);
        repeat (25) cycle(1'b0, 0, 0);

        offer(7);
        k = 0;
        do begin
            cycle(1'b0, 0, 0);
            k++;
        end while (offering && k < 60);
        check("wait_accept", edge_cnt, 32'(offering), 32'd0);
        cycle(1'b1, 0, 0);
        repeat (10) cycle(1'b0, 0, 0);

        offer(255);
        repeat (560) cycle(1'b0, 0, 0);
        offer(3);
        repeat (270) cycle(1'b0, 0, 0);

`ifdef CLK_INT_DIV_GATE_EN
        offer(4);
        repeat (21) cycle(1'b0, 0, 0);
        gate_i = 1'b1;
        repeat (12) cycle(1'b0, 0, 0);
        gate_i = 1'b0;
        repeat (20) cycle(1'b0, 0, 0);
        gate_i = 1'b1;
        cycle(1'b0, 0, 0);
        gate_i = 1'b0;
        repeat (20) cycle(1'b0, 0, 0);
`endif

        repeat (3000) begin
            cycle($urandom_range(199) == 0, 30, 5);
        end
        repeat (2) cycle(1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
